// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock that shares one uart_tx byte transmitter
// among NUM_REQ byte-stream requesters, pacing each byte on the busy flag.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int BUSY_TIMEOUT = 16,
  parameter int HOLD_TIMEOUT = 1_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_resetn,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic                 o_uart_tx_en,
  output logic [7:0]           o_uart_tx_data,
  input  logic                 i_uart_tx_busy,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_err_timeout,
  input  logic                 i_err_clr
);

  localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMAX = (HOLD_TIMEOUT > BUSY_TIMEOUT) ? HOLD_TIMEOUT : BUSY_TIMEOUT;
  localparam int CW   = $clog2(TMAX);
  localparam logic [CW-1:0] BUSY_LIM = CW'(BUSY_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t             r_state;
  logic [PW-1:0]      r_owner;
  logic [PW-1:0]      r_rr;
  logic               r_last;
  logic [7:0]         r_data;
  logic [CW-1:0]      r_cnt;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_err;

  state_t             w_state_nx;
  logic [PW-1:0]      w_owner_nx;
  logic [PW-1:0]      w_rr_nx;
  logic               w_last_nx;
  logic [7:0]         w_data_nx;
  logic [CW-1:0]      w_cnt_nx;
  logic [NUM_REQ-1:0] w_grant_nx;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_tx_en;
  logic               w_err_set;
  logic               w_done;
  logic               w_release;
  logic               w_pick_found;
  logic [PW-1:0]      w_pick_idx;

  function automatic logic [PW-1:0] f_rot(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PW'(s);
  endfunction

  // Search starts at the rotating pointer so the last releaser ranks lowest.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_pick_found && i_req_valid[f_rot(r_rr, i)]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = f_rot(r_rr, i);
      end
    end
  end

  // Requester handshake: a byte moves in the cycle where i_req_valid[k] and
  // o_req_ready[k] are both high; ready is a one-cycle pulse and the requester
  // holds valid/data/last stable until it sees it.
  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_rr_nx    = r_rr;
    w_last_nx  = r_last;
    w_data_nx  = r_data;
    w_cnt_nx   = r_cnt;
    w_grant_nx = r_grant;
    w_ready    = '0;
    w_tx_en    = 1'b0;
    w_err_set  = 1'b0;
    w_done     = 1'b0;
    w_release  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_found) begin
          w_ready[w_pick_idx]    = 1'b1;
          w_owner_nx             = w_pick_idx;
          w_data_nx              = i_req_data[int'(w_pick_idx)*8 +: 8];
          w_last_nx              = i_req_last[w_pick_idx];
          w_grant_nx             = '0;
          w_grant_nx[w_pick_idx] = 1'b1;
          w_state_nx             = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!i_uart_tx_busy) begin
          w_tx_en    = 1'b1;
          w_cnt_nx   = '0;
          w_state_nx = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (i_uart_tx_busy) begin
          w_state_nx = S_WAIT_LO;
        end else if (r_cnt == BUSY_LIM) begin
          w_err_set = 1'b1;
          w_done    = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      S_WAIT_LO: begin
        if (!i_uart_tx_busy) w_done = 1'b1;
      end
      S_HOLD: begin
        if (i_req_valid[r_owner]) begin
          w_ready[r_owner] = 1'b1;
          w_data_nx        = i_req_data[int'(r_owner)*8 +: 8];
          w_last_nx        = i_req_last[r_owner];
          w_cnt_nx         = '0;
          w_state_nx       = S_ISSUE;
        end else if (r_cnt == HOLD_LIM) begin
          w_err_set = 1'b1;
          w_release = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_done) begin
      if (r_last) begin
        w_release = 1'b1;
      end else begin
        w_state_nx = S_HOLD;
        w_cnt_nx   = '0;
      end
    end
    if (w_release) begin
      w_state_nx = S_IDLE;
      w_grant_nx = '0;
      w_rr_nx    = f_rot(r_owner, 1);
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_rr    <= '0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_owner <= w_owner_nx;
      r_rr    <= w_rr_nx;
      r_last  <= w_last_nx;
      r_data  <= w_data_nx;
      r_cnt   <= w_cnt_nx;
      r_grant <= w_grant_nx;
      if (w_err_set) r_err <= 1'b1;
      else if (i_err_clr) r_err <= 1'b0;
    end
  end

  // Ready is combinational on valid, so mask it while reset is held.
  assign o_req_ready    = w_ready & {NUM_REQ{i_resetn}};
  assign o_uart_tx_en   = w_tx_en;
  assign o_uart_tx_data = r_data;
  assign o_grant        = r_grant;
  assign o_err_timeout  = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx busy model and
// an expected-byte queue checked on every transmit strobe.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 2;
  localparam int BUSY_TIMEOUT = 16;
  localparam int HOLD_TIMEOUT = 8;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_en;
  logic [7:0]           tx_data;
  logic                 busy;
  logic [NUM_REQ-1:0]   grant;
  logic                 err;
  logic                 err_clr;

  logic                 busy_never;
  logic [7:0]           exp_q[$];
  int                   n_chk;
  int                   n_pass;
  int                   n_fail;
  int                   en_cnt;
  int                   rdy_cnt[NUM_REQ];

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .BUSY_TIMEOUT(BUSY_TIMEOUT),
    .HOLD_TIMEOUT(HOLD_TIMEOUT)
  ) dut (
    .i_clk         (clk),
    .i_resetn      (resetn),
    .i_req_valid   (req_valid),
    .i_req_data    (req_data),
    .i_req_last    (req_last),
    .o_req_ready   (req_ready),
    .o_uart_tx_en  (tx_en),
    .o_uart_tx_data(tx_data),
    .i_uart_tx_busy(busy),
    .o_grant       (grant),
    .o_err_timeout (err),
    .i_err_clr     (err_clr)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // uart_tx model: busy rises one cycle after the strobe and stays high 10 cycles
  initial begin : uart_model
    int   left;
    logic en_seen;
    left = 0;
    busy = 1'b0;
    forever begin
      @(negedge clk);
      en_seen = tx_en;
      @(posedge clk);
      #1;
      if (en_seen && !busy_never) left = 10;
      busy = (left != 0);
      if (left != 0) left--;
    end
  end

  // scoreboard: every strobe must match the next expected byte
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (tx_en) begin
        en_cnt++;
        chk("tx_pending", (exp_q.size() > 0), 1'b1);
        if (exp_q.size() > 0) chk("tx_data", tx_data, exp_q.pop_front());
      end
      for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) rdy_cnt[k]++;
      if (|req_ready) chk("ready_onehot", $onehot(req_ready), 1'b1);
    end
  end

  // drivers
  task automatic set_req(input int k, input logic v, input logic [7:0] d, input logic l);
    req_valid[k]       = v;
    req_data[8*k +: 8] = d;
    req_last[k]        = l;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    err_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    en_cnt = 0;
    for (int k = 0; k < NUM_REQ; k++) rdy_cnt[k] = 0;
  endtask

  task automatic wait_ready_k(input int k, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[k] && n < budget);
    chk($sformatf("ready%0d_seen", k), req_ready[k], 1'b1);
  endtask

  task automatic wait_grant_zero(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant != '0 && n < budget);
    chk("grant_release", grant, '0);
  endtask

  task automatic wait_readies(input int target, input int budget);
    int seen;
    int cyc;
    seen = 0;
    cyc  = 0;
    while (seen < target && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (|req_ready) seen++;
    end
    chk("ready_pulses", seen, target);
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    n_fail     = 0;
    en_cnt     = 0;
    busy_never = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) rdy_cnt[k] = 0;

    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_grant", grant, '0);
    chk("rst_ready", req_ready, '0);
    chk("rst_en", tx_en, 1'b0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_err", err, 1'b0);

    // single byte, 1-cycle accept-to-strobe latency
    do_reset();
    exp_q.push_back(8'h41);
    set_req(0, 1'b1, 8'h41, 1'b1);
    wait_ready_k(0, 10);
    @(posedge clk); #1;
    set_req(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t1_en", tx_en, 1'b1);
    chk("t1_grant", grant, 2'b01);
    wait_grant_zero(40);
    chk("t1_en_cnt", en_cnt, 1);
    chk("t1_rdy0_cnt", rdy_cnt[0], 1);
    chk("t1_err", err, 1'b0);
    chk("t1_q_empty", exp_q.size(), 0);

    // contention: strict alternation of single-byte packets
    do_reset();
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h20);
    set_req(0, 1'b1, 8'h10, 1'b1);
    set_req(1, 1'b1, 8'h20, 1'b1);
    wait_readies(4, 100);
    @(posedge clk); #1;
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b0, 8'h00, 1'b0);
    wait_grant_zero(40);
    chk("t2_rdy0_cnt", rdy_cnt[0], 2);
    chk("t2_rdy1_cnt", rdy_cnt[1], 2);
    chk("t2_q_empty", exp_q.size(), 0);

    // packet lock: req1 waits for the whole req0 packet
    do_reset();
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'hB0);
    set_req(0, 1'b1, 8'hA1, 1'b0);
    set_req(1, 1'b1, 8'hB0, 1'b1);
    wait_ready_k(0, 10);
    @(posedge clk); #1;
    set_req(0, 1'b1, 8'hA2, 1'b0);
    wait_ready_k(0, 60);
    @(posedge clk); #1;
    set_req(0, 1'b1, 8'hA3, 1'b1);
    wait_ready_k(0, 60);
    @(posedge clk); #1;
    set_req(0, 1'b0, 8'h00, 1'b0);
    wait_ready_k(1, 60);
    chk("t3_en_before_b0", en_cnt, 3);
    chk("t3_idle_at_b0", grant, '0);
    @(posedge clk); #1;
    set_req(1, 1'b0, 8'h00, 1'b0);
    wait_grant_zero(40);
    chk("t3_rdy0_cnt", rdy_cnt[0], 3);
    chk("t3_rdy1_cnt", rdy_cnt[1], 1);
    chk("t3_q_empty", exp_q.size(), 0);

    // busy timeout: WAIT_HI lasts BUSY_TIMEOUT cycles, the flag registers at its end
    busy_never = 1'b1;
    do_reset();
    exp_q.push_back(8'h77);
    set_req(0, 1'b1, 8'h77, 1'b1);
    wait_ready_k(0, 10);
    @(posedge clk); #1;
    set_req(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t4_en", tx_en, 1'b1);
    repeat (BUSY_TIMEOUT) @(negedge clk);
    chk("t4_err_before", err, 1'b0);
    chk("t4_grant_before", grant, 2'b01);
    @(negedge clk);
    chk("t4_err_set", err, 1'b1);
    chk("t4_grant_after", grant, '0);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(negedge clk);
    chk("t4_err_held", err, 1'b1);
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("t4_err_cleared", err, 1'b0);
    chk("t4_q_empty", exp_q.size(), 0);
    busy_never = 1'b0;

    // hold timeout with a clear colliding on the setting edge
    do_reset();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h66);
    set_req(0, 1'b1, 8'h55, 1'b0);
    set_req(1, 1'b1, 8'h66, 1'b1);
    wait_ready_k(0, 10);
    @(posedge clk); #1;
    set_req(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t5_en", tx_en, 1'b1);
    repeat (18) @(negedge clk);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(negedge clk);
    chk("t5_err_before", err, 1'b0);
    chk("t5_grant_hold", grant, 2'b01);
    chk("t5_ready_hold", req_ready, 2'b00);
    @(negedge clk);
    chk("t5_err_set_wins", err, 1'b1);
    chk("t5_grant_released", grant, '0);
    chk("t5_ready1", req_ready, 2'b10);
    @(posedge clk); #1;
    err_clr = 1'b0;
    set_req(1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t5_err_cleared", err, 1'b0);
    wait_grant_zero(40);
    chk("t5_q_empty", exp_q.size(), 0);

    // reset in WAIT_LO of a locked packet
    do_reset();
    exp_q.push_back(8'h90);
    set_req(0, 1'b1, 8'h90, 1'b0);
    wait_ready_k(0, 10);
    @(posedge clk); #1;
    set_req(0, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b0;
    exp_q.push_back(8'hC2);
    set_req(1, 1'b1, 8'hC2, 1'b1);
    #1;
    chk("t6_rst_grant", grant, '0);
    chk("t6_rst_ready", req_ready, '0);
    chk("t6_rst_en", tx_en, 1'b0);
    chk("t6_rst_data", tx_data, 8'h00);
    chk("t6_rst_err", err, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("t6_ready1_first", req_ready, 2'b10);
    @(posedge clk); #1;
    set_req(1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t6_grant1", grant, 2'b10);
    wait_grant_zero(60);
    chk("t6_q_empty", exp_q.size(), 0);
    chk("t6_err", err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
